// File: rtl/ex.sv
// rtl/ex.sv - execute stage: logic/shift ALU, HI/LO registers and multi-cycle divider
//
// Purpose: combinational logic, shift and LUI results with zero latency, plus a
// restoring radix-2 divider (DIV/DIVU) that stalls upstream while it iterates
// and writes quotient/remainder into LO/HI.
//
// Ports:
//   clk       in   clock, all state on rising edge
//   rst       in   asynchronous active-high reset
//   aluop_i   in   [7:0]  operation code from decode
//   reg1_i    in   [31:0] operand 1 (rs, or shift amount)
//   reg2_i    in   [31:0] operand 2 (rt, or zero-extended immediate)
//   wd_i      in   [4:0]  destination register index
//   wreg_i    in   destination write enable
//   flush_i   in   abort any in-progress divide
//   wdata_o   out  [31:0] result (also the forwarding value)
//   wd_o      out  [4:0]  destination register index
//   wreg_o    out  destination write enable
//   stall_o   out  upstream holds ID/EX contents while high

module ex (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        flush_i,
    output logic [31:0] wdata_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic        stall_o
);

    localparam logic [7:0] OP_AND  = 8'b00100100;
    localparam logic [7:0] OP_OR   = 8'b00100101;
    localparam logic [7:0] OP_XOR  = 8'b00100110;
    localparam logic [7:0] OP_NOR  = 8'b00100111;
    localparam logic [7:0] OP_ANDI = 8'b01011001;
    localparam logic [7:0] OP_XORI = 8'b01011011;
    localparam logic [7:0] OP_SLL  = 8'b01111100;
    localparam logic [7:0] OP_SLLV = 8'b00000100;
    localparam logic [7:0] OP_SRL  = 8'b00000010;
    localparam logic [7:0] OP_SRLV = 8'b00000110;
    localparam logic [7:0] OP_SRA  = 8'b00000011;
    localparam logic [7:0] OP_SRAV = 8'b00000111;
    localparam logic [7:0] OP_LUI  = 8'b01011100;
    localparam logic [7:0] OP_MFHI = 8'b00010000;
    localparam logic [7:0] OP_MFLO = 8'b00010010;
    localparam logic [7:0] OP_DIV  = 8'b00011010;
    localparam logic [7:0] OP_DIVU = 8'b00011011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] dvd_q;     // dividend shifting out MSB-first, quotient shifting in at LSB
    logic [31:0] dvs_q;     // absolute divisor
    logic [31:0] rem_q;     // partial remainder
    logic        neg_quot_q;
    logic        neg_rem_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_div;
    logic        is_signed;
    logic [31:0] abs1_d;
    logic [31:0] abs2_d;
    logic [32:0] rem_shift_d;
    logic        qbit_d;
    logic [31:0] rem_next_d;
    logic [31:0] result_d;
    logic [4:0]  sh;

    assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign is_signed = (aluop_i == OP_DIV);
    assign abs1_d    = (is_signed && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign abs2_d    = (is_signed && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;

    // One restoring step: bring down the next dividend bit, subtract if it fits.
    // When the subtraction happens the result is below the divisor, so 32 bits hold it.
    assign rem_shift_d = {rem_q, dvd_q[31]};
    assign qbit_d      = (rem_shift_d >= {1'b0, dvs_q});
    assign rem_next_d  = qbit_d ? (rem_shift_d[31:0] - dvs_q) : rem_shift_d[31:0];

    assign sh = reg1_i[4:0];

    always_comb begin
        result_d = 32'd0;
        case (aluop_i)
            OP_AND, OP_ANDI: result_d = reg1_i & reg2_i;
            OP_OR:           result_d = reg1_i | reg2_i;
            OP_XOR, OP_XORI: result_d = reg1_i ^ reg2_i;
            OP_NOR:          result_d = ~(reg1_i | reg2_i);
            OP_SLL, OP_SLLV: result_d = reg2_i << sh;
            OP_SRL, OP_SRLV: result_d = reg2_i >> sh;
            OP_SRA, OP_SRAV: result_d = $signed(reg2_i) >>> sh;
            OP_LUI:          result_d = {reg2_i[15:0], 16'h0000};
            OP_MFHI:         result_d = hi_q;
            OP_MFLO:         result_d = lo_q;
            default:         result_d = 32'd0;
        endcase
    end

    // Outputs are forced low by reset immediately, not only at the next edge.
    assign wdata_o = rst ? 32'd0 : result_d;
    assign wd_o    = rst ? 5'd0  : wd_i;
    assign wreg_o  = rst ? 1'b0  : (wreg_i && !is_div);
    assign stall_o = !rst && !flush_i &&
                     (((state_q == S_IDLE) && is_div) || (state_q == S_BUSY));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            dvd_q      <= 32'd0;
            dvs_q      <= 32'd0;
            rem_q      <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (is_div) begin
                        cnt_q <= 5'd0;
                        if (reg2_i == 32'd0) begin
                            // Divide by zero: all-ones quotient, raw dividend as remainder.
                            dvd_q      <= 32'hFFFF_FFFF;
                            rem_q      <= reg1_i;
                            neg_quot_q <= 1'b0;
                            neg_rem_q  <= 1'b0;
                            state_q    <= S_DONE;
                        end else begin
                            dvd_q      <= abs1_d;
                            dvs_q      <= abs2_d;
                            rem_q      <= 32'd0;
                            neg_quot_q <= is_signed && (reg1_i[31] ^ reg2_i[31]);
                            neg_rem_q  <= is_signed && reg1_i[31];
                            state_q    <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    rem_q <= rem_next_d;
                    dvd_q <= {dvd_q[30:0], qbit_d};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    lo_q    <= neg_quot_q ? (~dvd_q + 32'd1) : dvd_q;
                    hi_q    <= neg_rem_q  ? (~rem_q + 32'd1) : rem_q;
                    cnt_q   <= 5'd0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
